// File: rtl/shift_decoder_pkg.sv
// Shared constants and types for the nibble shift encoder/decoder pair.
// Holds shift-control codes, field widths and the decoded result bundle.
package shift_pkg;

  localparam int NIB_W  = 4;
  localparam int WORD_W = 8;

  typedef logic [1:0] shift_t;

  localparam shift_t SHIFT_NONE = 2'b00;
  localparam shift_t SHIFT_2    = 2'b01;
  localparam shift_t SHIFT_4    = 2'b10;

  typedef struct packed {
    logic [NIB_W-1:0] nib;
    shift_t           cntrl;
    logic             err;
  } dec_t;

endpackage

// File: rtl/shift_decoder_if.sv
// Valid/ready bundle for shifted words in and decoded nibbles out.
// master: word source / nibble sink; slave: the decoder.
interface shift_decoder_if;
  import shift_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  shift_t            in_cntrl;
  logic              out_valid;
  logic              out_ready;
  logic [NIB_W-1:0]  out_data;
  shift_t            out_cntrl;
  logic              out_err;

  modport master (
    output in_valid,
    output in_data,
    output in_cntrl,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_cntrl,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_cntrl,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_cntrl,
    output out_err
  );

endinterface

// File: rtl/shift_decoder_window_decode.sv
// Combinational window extract: data/cntrl in, nibble/err out.
// err flags any set bit outside the selected 4-bit window.
module shift_window_decode
  import shift_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  shift_t            cntrl,
  output logic [NIB_W-1:0]  nibble,
  output logic              err
);

  always_comb begin
    nibble = data[3:0];
    err    = |data[7:4];
    unique case (1'b1)
      (cntrl == SHIFT_2): begin
        nibble = data[5:2];
        err    = |data[7:6]
               | |data[1:0];
      end
      (cntrl == SHIFT_4): begin
        nibble = data[7:4];
        err    = |data[3:0];
      end
      default: begin
        nibble = data[3:0];
        err    = |data[7:4];
      end
    endcase
  end

endmodule

// File: rtl/shift_decoder.sv
// Single-stage decoder: clk, rst_n, bus (slave), clr_cnt, err_count.
// SHIFT_DECODER_ERRCNT_EN builds the saturating error counter.
module shift_decoder
  import shift_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_decoder_if.slave   bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_count
);

  logic [NIB_W-1:0] dec_nib;
  logic             dec_err;
  logic             vld_q;
  dec_t             res_q;
  logic             in_rdy;
  logic             in_xfer;
  logic             out_xfer;

  shift_window_decode u_dec (
    .data   (bus.in_data),
    .cntrl  (bus.in_cntrl),
    .nibble (dec_nib),
    .err    (dec_err)
  );

  assign in_rdy   = !vld_q || bus.out_ready;
  assign in_xfer  = bus.in_valid && in_rdy;
  assign out_xfer = vld_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      res_q <= '0;
    end else if (in_xfer) begin
      vld_q       <= 1'b1;
      res_q.nib   <= dec_nib;
      res_q.cntrl <= bus.in_cntrl;
      res_q.err   <= dec_err;
    end else if (out_xfer) begin
      vld_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = res_q.nib;
  assign bus.out_cntrl = res_q.cntrl;
  assign bus.out_err   = res_q.err;

`ifdef SHIFT_DECODER_ERRCNT_EN
  logic [CNT_W-1:0] cnt_q;

  // clear wins over increment; stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_cnt) begin
      cnt_q <= '0;
    end else if (in_xfer && dec_err
                 && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign err_count = cnt_q;
`else
  logic unused_clr;

  assign unused_clr = clr_cnt;
  assign err_count  = '0;
`endif

endmodule

// File: tb/tb_shift_decoder.sv
// Self-checking bench for shift_decoder (CNT_W=8 and CNT_W=2 copies).
// Directed steps then random traffic against a queue reference model.
module tb_shift_decoder;
  import shift_pkg::*;

`ifdef SHIFT_DECODER_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_cnt;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  shift_decoder_if bus_a ();
  shift_decoder_if bus_b ();

  shift_decoder #(.CNT_W(8)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_a),
    .clr_cnt   (clr_cnt),
    .err_count (cnt_a)
  );

  shift_decoder #(.CNT_W(2)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_b),
    .clr_cnt   (clr_cnt),
    .err_count (cnt_b)
  );

  typedef struct {
    logic [3:0] nib;
    logic [1:0] c;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   ma;
  int   mb;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Window position = shift amount; anything outside it is an error.
  function automatic exp_t ref_dec(input int dv, input int c);
    exp_t r;
    int   amt;
    amt   = (c == 1) ? 2 : (c == 2) ? 4 : 0;
    r.nib = 4'((dv >> amt) & 15);
    r.e   = ((dv & 255 & ~(15 << amt)) != 0);
    r.c   = 2'(c);
    return r;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic drive(input logic v, input logic [7:0] d,
                       input logic [1:0] c, input logic r,
                       input logic clr);
    bus_a.in_valid  = v;
    bus_a.in_data   = d;
    bus_a.in_cntrl  = c;
    bus_a.out_ready = r;
    bus_b.in_valid  = v;
    bus_b.in_data   = d;
    bus_b.in_cntrl  = c;
    bus_b.out_ready = r;
    clr_cnt         = clr;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d,
                       input logic [1:0] c, input logic r,
                       input logic clr);
    bit   pop;
    bit   push;
    exp_t e;
    @(negedge clk);
    drive(v, d, c, r, clr);
    #1;
    chk("in_ready", 32'(bus_a.in_ready),
        32'((q.size() == 0) || r));
    chk("out_valid", 32'(bus_a.out_valid),
        32'(q.size() != 0));
    chk("out_valid_b", 32'(bus_b.out_valid),
        32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_data", 32'(bus_a.out_data), 32'(q[0].nib));
      chk("out_cntrl", 32'(bus_a.out_cntrl), 32'(q[0].c));
      chk("out_err", 32'(bus_a.out_err), 32'(q[0].e));
      chk("out_data_b", 32'(bus_b.out_data), 32'(q[0].nib));
    end
    chk("err_count", 32'(cnt_a), 32'(ma));
    chk("err_count_b", 32'(cnt_b), 32'(mb));
    pop  = (q.size() != 0) && r;
    push = v && ((q.size() == 0) || r);
    e    = ref_dec(int'(d), int'(c));
    if (pop) void'(q.pop_front());
    if (push) q.push_back(e);
    if (CNT_EN) begin
      if (clr) begin
        ma = 0;
        mb = 0;
      end else if (push && e.e) begin
        ma = sat(ma + 1, 255);
        mb = sat(mb + 1, 3);
      end
    end
  endtask

  task automatic expect_out(input logic [3:0] nib,
                            input logic [1:0] c,
                            input logic e,
                            input int cnt);
    @(posedge clk);
    #1;
    chk("dir_valid", 32'(bus_a.out_valid), 32'd1);
    chk("dir_data", 32'(bus_a.out_data), 32'(nib));
    chk("dir_cntrl", 32'(bus_a.out_cntrl), 32'(c));
    chk("dir_err", 32'(bus_a.out_err), 32'(e));
    chk("dir_count", 32'(cnt_a),
        CNT_EN ? 32'(cnt) : 32'd0);
  endtask

  task automatic rand_drive();
    drive(1'($urandom_range(0, 1)), 8'($urandom),
          2'($urandom), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
  endtask

  initial begin
    ma = 0;
    mb = 0;
    rst_n = 1'b0;
    rand_drive();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_drive();
      #1;
      chk("rst_valid", 32'(bus_a.out_valid), 32'd0);
      chk("rst_data", 32'(bus_a.out_data), 32'd0);
      chk("rst_cntrl", 32'(bus_a.out_cntrl), 32'd0);
      chk("rst_err", 32'(bus_a.out_err), 32'd0);
      chk("rst_count", 32'(cnt_a), 32'd0);
      chk("rst_count_b", 32'(cnt_b), 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus_a.in_ready), 32'd1);

    cycle(1'b1, 8'h28, 2'b01, 1'b1, 1'b0);
    expect_out(4'hA, 2'b01, 1'b0, 0);
    cycle(1'b1, 8'h50, 2'b10, 1'b1, 1'b0);
    expect_out(4'h5, 2'b10, 1'b0, 0);
    cycle(1'b1, 8'h0C, 2'b00, 1'b1, 1'b0);
    expect_out(4'hC, 2'b00, 1'b0, 0);
    cycle(1'b1, 8'h53, 2'b10, 1'b1, 1'b0);
    expect_out(4'h5, 2'b10, 1'b1, 1);
    cycle(1'b1, 8'h1F, 2'b11, 1'b1, 1'b0);
    expect_out(4'hF, 2'b11, 1'b1, 2);

    cycle(1'b1, 8'h24, 2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 8'hB0, 2'b10, 1'b0, 1'b0);
    cycle(1'b1, 8'hB0, 2'b10, 1'b1, 1'b0);
    expect_out(4'hB, 2'b10, 1'b0, 2);
    cycle(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++)
      cycle(1'b1, 8'hFF, 2'b10, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("sat_count_b", 32'(cnt_b),
        CNT_EN ? 32'd3 : 32'd0);
    cycle(1'b1, 8'hFF, 2'b10, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("clr_count", 32'(cnt_a), 32'd0);
    chk("clr_count_b", 32'(cnt_b), 32'd0);

    cycle(1'b1, 8'h3C, 2'b01, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus_a.out_valid), 32'd0);
    chk("midrst_data", 32'(bus_a.out_data), 32'd0);
    chk("midrst_valid_b", 32'(bus_b.out_valid), 32'd0);
    q.delete();
    ma = 0;
    mb = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 1000; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom),
            2'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 49) == 0));
    cycle(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_decoder.md
Name: shift_decoder

Overview:
- Receive-side inverse of the team's nibble left-shifter (shift-by-0/2/4 into an 8-bit field).
- Accepts an 8-bit shifted word plus its 2-bit shift control over a valid/ready handshake, recovers the original 4-bit nibble, and flags words whose bits outside the selected window are non-zero.
- Registered single-stage pipeline with backpressure, plus a saturating error counter.
- Sits between the bus that carries shifted words and downstream nibble consumers.

Parameters:
- CNT_W, 8, width of the saturating error counter err_count.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  decoder can accept a word this cycle
- in_data  input  8  shifted word
- in_cntrl  input  2  shift control the word was encoded with
- out_valid  output  1  decoded nibble valid
- out_ready  input  1  downstream accepts the nibble
- out_data  output  4  recovered nibble
- out_cntrl  output  2  in_cntrl echoed with the word
- out_err  output  1  bits outside the window were non-zero
- clr_cnt  input  1  synchronous clear of err_count
- err_count  output  CNT_W  saturating count of accepted words with error

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: out_valid=0, out_data=0, out_cntrl=0, out_err=0, err_count=0. in_ready=1 from the first cycle after reset.
- Reset mid-transfer discards the held word; no partial output is kept.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational). Full throughput: one word per cycle when out_ready is held 1.
- Latency is 1 cycle: a word accepted at edge N appears on out_* after edge N and is held stable until its output transfer.
- Register update rules:
  - Input transfer: the output register loads the decoded result and out_valid is set to 1.
  - Output transfer without an input transfer: out_valid is cleared to 0.
  - Otherwise: all out_* hold their values.
  - Simultaneous input and output transfer: the new word replaces the old with no bubble.
- Decode, a pure function of in_data (d) and in_cntrl:
  - 2'b01: out_data=d[5:2]; err = |d[7:6] or |d[1:0].
  - 2'b10: out_data=d[7:4]; err = |d[3:0].
  - 2'b00 or 2'b11: out_data=d[3:0]; err = |d[7:4]. This matches the encoder's pass-through default.
  - out_data is always the window bits, even when err=1.
- err_count:
  - Increments by 1 on each input transfer whose decode has err=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - clr_cnt=1 forces 0 on the next edge and takes priority over a simultaneous increment.
- out_* while out_valid=0: hold their last values; downstream ignores them.

Optional Feature:
- Macro: SHIFT_DECODER_ERRCNT_EN.
- Defined: err_count and clr_cnt behave as described above.
- Undefined: no counter flops are built, err_count is tied to 0, and clr_cnt is ignored. out_err is unaffected.

Decomposition:
- Shared package shift_pkg holds:
  - shift-control constants SHIFT_NONE=2'b00, SHIFT_2=2'b01, SHIFT_4=2'b10;
  - NIB_W=4 and WORD_W=8, shared with the encoder.
- One natural sub-module: shift_window_decode, combinational; inputs data and cntrl, outputs nibble and err.
- Top level holds the handshake register and the counter.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, err_count=0, in_ready=1 after release.
- Clean decode: in_cntrl=01, in_data=8'h28, out_ready=1 -> next cycle out_data=4'hA, out_err=0, out_cntrl=01. Then cntrl=10, data=8'h50 -> out_data=4'h5, err=0. Then cntrl=00, data=8'h0C -> out_data=4'hC, err=0.
- Error detect: cntrl=10, data=8'h53 -> out_data=4'h5, out_err=1, err_count=1. Then cntrl=11, data=8'h1F -> out_data=4'hF, out_err=1, err_count=2.
- Backpressure: out_ready=0 with word A held -> in_ready=0 and out_* stable over 5 cycles. Raise out_ready with word B valid -> A transfers, B loads the same cycle, no bubble.
- Counter limits: CNT_W=2, five errored words -> err_count sticks at 3. clr_cnt=1 together with an errored word -> err_count=0.
- Streaming scoreboard: 1000 random words with random in_valid/out_ready -> output sequence equals the reference decode in order, with no drops or duplicates. Repeat with SHIFT_DECODER_ERRCNT_EN undefined -> err_count is always 0.
